uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- UART receiver: 8N1, LSB first, on the `RX` pad at 12 MHz / 115200 baud.
- Complements the stream transmitter on `TX`. Lets the host send control bytes to the design, e.g. start/stop PDM streaming or select gain.
- Delivers each received byte through a 1-deep valid/ready output register.
- Flags framing errors and overruns.

Parameters:
- CLK_FREQ, 12000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 104), clocks per bit period.
- HALF_BIT, CLKS_PER_BIT/2 (52), clocks from start-bit detection to start-bit centre.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- resetn  input  1  synchronous, active-low reset.
- rx  input  1  asynchronous serial line; idles high.
- data  output  8  received byte; valid while valid=1.
- valid  output  1  data holds an unconsumed byte.
- ready  input  1  consumer accepts data when valid&&ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while output register still full; that byte is dropped.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- rx passes through a 2-FF synchronizer; both FFs reset to 1. All decisions use the second FF output, rx_s.
- On reset:
  - state=IDLE, bit counter=0, baud counter=0, shift register=0.
  - data=0, valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame abandons the frame; no valid, no error pulse.
- State IDLE:
  - rx_s==0 → START; baud counter cleared.
- State START:
  - Baud counter counts 0..HALF_BIT-1.
  - At HALF_BIT-1, sample rx_s. If 0 → DATA, counters cleared.
  - If 1 (glitch shorter than half a bit) → IDLE; no flags raised.
- State DATA:
  - Baud counter counts 0..CLKS_PER_BIT-1.
  - At terminal count, shift rx_s in at the MSB (right-shift), so the first received bit ends up at data[0].
  - After the 8th bit → STOP.
- State STOP:
  - At terminal count CLKS_PER_BIT-1, sample rx_s.
  - If 1 → deliver and go to IDLE. This happens mid-stop-bit, so back-to-back frames are received without gaps.
  - If 0 → pulse frame_err, do not deliver, go to BREAK.
- State BREAK:
  - Wait until rx_s==1, then → IDLE. A held-low line (break) produces exactly one frame_err.
- Delivery, on the cycle after the stop sample:
  - If valid==0, or valid&&ready that same cycle: data←shift register, valid←1.
  - Otherwise: overrun pulses 1 cycle; data and valid are unchanged.
- Consumption:
  - valid&&ready with no delivery that cycle → valid←0 next cycle. data holds its last value.
- Latency (defaults): valid rises exactly 991 clk edges after the first clk edge at which rx is sampled low at the pin.
  - Breakdown: 2 sync + 52 + 8×104 data + 104 stop + 1 register.
- Every counter is sized for CLKS_PER_BIT-1 and never wraps in normal operation.
- All outputs are registered.

Test Plan:
- Idle line high, send 0x55 at 104 clk/bit, ready=1 → valid high for 1 cycle 991 clks after start edge; data=0x55; frame_err=overrun=0.
- Send 0xA5 then 0x3C back-to-back (no idle gap), ready=1 → two valid pulses 1040 clks apart; data 0xA5 then 0x3C.
- ready=0, send 0x12 then 0x34 → data stays 0x12, valid stays 1; overrun pulses once at the second byte's delivery. Then ready=1 → valid drops next cycle.
- Send 0x81 with stop bit low, then hold rx low 3000 clks → exactly one frame_err pulse, no valid, busy=1 until rx returns high, then IDLE.
- 30-clk low glitch on rx → busy rises, then falls after the start-centre sample; no valid or flags. A following real byte 0xF0 is received correctly.
- Assert resetn=0 for 1 clk during DATA bit 4 of 0xC3, line then idle → busy=0, valid=0 after reset. The next full byte 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first. Each received byte is handed out through a
// one-deep valid/ready register; framing errors and overruns are flagged as one-cycle pulses.
module uart_rx_byte #(
    parameter int CLK_FREQ     = 12000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t          state_q;
    logic            sync1_q;
    logic            rx_s_q;
    logic [CW-1:0]   baud_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            frame_err_q;
    logic            overrun_q;
    logic            busy_q;
    logic            deliver_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            deliver_q   <= 1'b0;
        end else begin
            sync1_q     <= rx;
            rx_s_q      <= sync1_q;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            deliver_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        baud_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_q == CW'(HALF_BIT - 1)) begin
                        baud_q <= '0;
                        bit_q  <= '0;
                        // A start bit that is gone by its centre is treated as line noise.
                        if (!rx_s_q) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_q == CW'(CLKS_PER_BIT - 1)) begin
                        baud_q  <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            bit_q   <= '0;
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_q == CW'(CLKS_PER_BIT - 1)) begin
                        baud_q <= '0;
                        // Leaving mid-stop-bit lets a back-to-back start edge be caught.
                        if (rx_s_q) begin
                            deliver_q <= 1'b1;
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BRK;
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                BRK: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (deliver_q) begin
                if (!valid_q || ready) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: a timeline model of the receiver (sample points as offsets
// from the detected start edge) is compared with the DUT every cycle, plus literal checks per scenario.
module tb_uart_rx_byte;
    logic       clk = 1'b0;
    logic       resetn;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_byte dut (
        .clk       (clk),
        .resetn    (resetn),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    // Reference model state
    logic       m_on = 1'b0;
    logic       d1 = 1'b1, d2 = 1'b1;
    int         m_mode = 0;     // 0 idle, 1 in frame, 2 waiting for line release
    int         m_t = 0;
    logic [7:0] m_acc = 8'h00;
    logic [7:0] m_pend_byte = 8'h00;
    logic       m_pend = 1'b0;
    int         m_last_deliver = 0;
    logic [7:0] e_data = 8'h00;
    logic       e_valid = 1'b0, e_ferr = 1'b0, e_ovr = 1'b0, e_busy = 1'b0;

    // Observed events
    int         rise_cyc[$];
    logic [7:0] rise_data[$];
    int         n_ferr = 0;
    int         n_ovr = 0;
    logic       v_prev = 1'b0;

    always @(posedge clk) begin : model
        int   k;
        logic s;
        cyc = cyc + 1;
        if (!resetn) begin
            m_on = 1'b1;
            d1 = 1'b1; d2 = 1'b1;
            m_mode = 0; m_pend = 1'b0; m_acc = 8'h00;
            e_data = 8'h00; e_valid = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0; e_busy = 1'b0;
        end else begin
            s  = d2;        // line value as seen two clocks late
            d2 = d1;
            d1 = rx;
            e_ferr = 1'b0;
            e_ovr  = 1'b0;
            if (m_pend) begin
                if (!e_valid || ready) begin
                    e_data = m_pend_byte;
                    e_valid = 1'b1;
                    m_last_deliver = cyc;
                end else begin
                    e_ovr = 1'b1;
                end
            end else if (e_valid && ready) begin
                e_valid = 1'b0;
            end
            m_pend = 1'b0;
            if (m_mode == 0) begin
                if (!s) begin
                    m_mode = 1;
                    m_t = cyc;
                    m_acc = 8'h00;
                end
            end else if (m_mode == 1) begin
                k = cyc - m_t;
                if (k == 52) begin
                    if (s) m_mode = 0;
                end else if (k > 52 && (k - 52) % 104 == 0) begin
                    if (k < 52 + 9 * 104) begin
                        m_acc[(k - 52) / 104 - 1] = s;
                    end else if (s) begin
                        m_pend = 1'b1;
                        m_pend_byte = m_acc;
                        m_mode = 0;
                    end else begin
                        e_ferr = 1'b1;
                        m_mode = 2;
                    end
                end
            end else begin
                if (s) m_mode = 0;
            end
            e_busy = (m_mode != 0);
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            checks = checks + 1;
            if ({data, valid, busy, frame_err, overrun} !== {e_data, e_valid, e_busy, e_ferr, e_ovr})
                $display("FAIL cycle_compare @%0d: got data=%h valid=%b busy=%b ferr=%b ovr=%b, expected data=%h valid=%b busy=%b ferr=%b ovr=%b",
                         cyc, data, valid, busy, frame_err, overrun, e_data, e_valid, e_busy, e_ferr, e_ovr);
            else
                passed = passed + 1;
        end
        if (valid === 1'b1 && !v_prev) begin
            rise_cyc.push_back(cyc);
            rise_data.push_back(data);
            $display("rx byte 0x%02h at cycle %0d", data, cyc);
        end
        v_prev = (valid === 1'b1);
        if (frame_err === 1'b1) begin
            n_ferr = n_ferr + 1;
            $display("frame error at cycle %0d", cyc);
        end
        if (overrun === 1'b1) begin
            n_ovr = n_ovr + 1;
            $display("overrun at cycle %0d", cyc);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act == exp) passed = passed + 1;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rise_cyc.delete();
        rise_data.delete();
        n_ferr = 0;
        n_ovr  = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int cpb);
        rx = 1'b0;
        tick(cpb);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(cpb);
        end
        rx = stop_ok;
        tick(cpb);
    endtask

    initial begin
        int         t_low;
        logic [7:0] b;
        rx = 1'b1; ready = 1'b1; resetn = 1'b0;
        tick(3);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_data", int'(data), 0);
        resetn = 1'b1;
        tick(10);

        // Single byte latency
        clear_mon();
        t_low = cyc + 1;
        send_frame(8'h55, 1'b1, 104);
        tick(20);
        chk("t1_count", rise_cyc.size(), 1);
        if (rise_cyc.size() >= 1) begin
            chk("t1_latency", rise_cyc[0] - t_low, 991);
            chk("t1_data", int'(rise_data[0]), 8'h55);
        end
        chk("t1_model_latency", m_last_deliver - t_low, 991);
        chk("t1_flags", n_ferr + n_ovr, 0);

        // Back-to-back frames
        clear_mon();
        send_frame(8'hA5, 1'b1, 104);
        send_frame(8'h3C, 1'b1, 104);
        tick(20);
        chk("t2_count", rise_cyc.size(), 2);
        if (rise_cyc.size() == 2) begin
            chk("t2_spacing", rise_cyc[1] - rise_cyc[0], 1040);
            chk("t2_data0", int'(rise_data[0]), 8'hA5);
            chk("t2_data1", int'(rise_data[1]), 8'h3C);
        end

        // Overrun while the consumer stalls
        clear_mon();
        ready = 1'b0;
        send_frame(8'h12, 1'b1, 104);
        send_frame(8'h34, 1'b1, 104);
        tick(20);
        chk("t3_data_held", int'(data), 8'h12);
        chk("t3_valid_held", int'(valid), 1);
        chk("t3_overruns", n_ovr, 1);
        ready = 1'b1;
        tick(1);
        chk("t3_valid_drop", int'(valid), 0);

        // Bad stop bit followed by a long break
        clear_mon();
        send_frame(8'h81, 1'b0, 104);
        tick(3000);
        chk("t4_busy_in_break", int'(busy), 1);
        rx = 1'b1;
        tick(10);
        chk("t4_busy_after", int'(busy), 0);
        chk("t4_ferr_count", n_ferr, 1);
        chk("t4_no_valid", rise_cyc.size(), 0);

        // Short glitch, then a real byte
        clear_mon();
        rx = 1'b0;
        tick(30);
        rx = 1'b1;
        chk("t5_busy_rise", int'(busy), 1);
        tick(60);
        chk("t5_busy_fall", int'(busy), 0);
        chk("t5_no_events", rise_cyc.size() + n_ferr + n_ovr, 0);
        tick(100);
        send_frame(8'hF0, 1'b1, 104);
        tick(20);
        chk("t5_count", rise_cyc.size(), 1);
        if (rise_cyc.size() >= 1) chk("t5_data", int'(rise_data[0]), 8'hF0);

        // Reset in the middle of a frame
        clear_mon();
        b = 8'hC3;
        rx = 1'b0;
        tick(104);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(104);
        end
        rx = b[4];
        tick(50);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        rx = 1'b1;
        tick(300);
        chk("t6_busy", int'(busy), 0);
        chk("t6_valid", int'(valid), 0);
        send_frame(8'h7E, 1'b1, 104);
        tick(20);
        chk("t6_count", rise_cyc.size(), 1);
        if (rise_cyc.size() >= 1) chk("t6_data", int'(rise_data[0]), 8'h7E);
        chk("t6_no_ferr", n_ferr, 0);

        // Randomized traffic, checked by the per-cycle model comparison
        for (int f = 0; f < 20; f++) begin
            ready = ($urandom_range(0, 3) != 0);
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0),
                       $urandom_range(100, 108));
            if (rx == 1'b0) tick($urandom_range(1, 400));
            rx = 1'b1;
            ready = ($urandom_range(0, 1) != 0);
            tick($urandom_range(0, 200));
        end
        ready = 1'b1;
        tick(1200);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
